// File: rtl/pe_cfg_pkg.sv
// pe_cfg_pkg: PE geometry, per-layer weight-length table and scheduler state encoding
package pe_cfg_pkg;
    localparam int CFG_IA_ROW     = 16;
    localparam int CFG_IA_COL     = 16;
    localparam int CFG_H_STEP     = 16;
    localparam int CFG_NUM_SETS   = 3;
    localparam int CFG_IA_CHANNEL = 8;
    localparam int CFG_W_C_LENGTH = 474;
    localparam int LEN_W          = $clog2(CFG_W_C_LENGTH);

    localparam int W_C_LENGTH_L1_S0 = 123;
    localparam int W_C_LENGTH_L1_S1 = 130;
    localparam int W_C_LENGTH_L1_S2 = 124;
    localparam int W_C_LENGTH_L2_S0 = 474;
    localparam int W_C_LENGTH_L2_S1 = 460;
    localparam int W_C_LENGTH_L2_S2 = 446;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_RUN, ST_WB, ST_RELEASE, ST_ADV, ST_DONE
    } state_e;

    // One extra bit keeps len+31 from overflowing at the maximum length.
    function automatic logic [LEN_W-1:0] w_iters_of(input logic [LEN_W-1:0] len);
        return LEN_W'(({1'b0, len} + (LEN_W + 1)'(31)) >> 5);
    endfunction

    function automatic logic [LEN_W-1:0] w_len_of(input logic layer, input logic [1:0] s);
        int l1, l2;
        l1 = (s == 2'd0) ? W_C_LENGTH_L1_S0 : (s == 2'd1) ? W_C_LENGTH_L1_S1 : W_C_LENGTH_L1_S2;
        l2 = (s == 2'd0) ? W_C_LENGTH_L2_S0 : (s == 2'd1) ? W_C_LENGTH_L2_S1 : W_C_LENGTH_L2_S2;
        return LEN_W'(layer ? l2 : l1);
    endfunction
endpackage

// File: rtl/tile_counter.sv
// tile_counter: nested set / row-tile / column counter with a last-tile flag
module tile_counter #(
    parameter int NUM_SETS = 3,
    parameter int IA_ROW   = 16,
    parameter int H_STEP   = 16,
    parameter int IA_COL   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clr,
    input  logic                      i_step,
    output logic [1:0]                o_s,
    output logic [$clog2(IA_ROW)-1:0] o_h,
    output logic [$clog2(IA_COL)-1:0] o_w,
    output logic                      o_last
);
    localparam int HW = $clog2(IA_ROW);
    localparam int WW = $clog2(IA_COL);

    logic [1:0]    s_q, s_d;
    logic [HW-1:0] h_q, h_d;
    logic [WW-1:0] w_q, w_d;
    logic          w_end, h_end, s_end;

    always_comb begin
        w_end = w_q == WW'(IA_COL - 1);
        h_end = h_q == HW'(IA_ROW - H_STEP);
        s_end = s_q == 2'(NUM_SETS - 1);
        w_d   = (i_clr || w_end) ? '0 : w_q + 1'b1;
        h_d   = (i_clr || (w_end && h_end)) ? '0 : w_end ? h_q + HW'(H_STEP) : h_q;
        s_d   = i_clr ? '0 : (w_end && h_end) ? s_q + 1'b1 : s_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s_q <= '0;
            h_q <= '0;
            w_q <= '0;
        end else if (i_clr || i_step) begin
            s_q <= s_d;
            h_q <= h_d;
            w_q <= w_d;
        end
    end

    assign o_s    = s_q;
    assign o_h    = h_q;
    assign o_w    = w_q;
    assign o_last = s_end && h_end && w_end;
endmodule

// File: rtl/pe_sched_ctrl.sv
// pe_sched_ctrl: layer sequencer that walks every (set, row tile, column) and runs
// the PE start/finish handshake plus the OA write-back handshake once per tile
module pe_sched_ctrl
    import pe_cfg_pkg::*;
#(
    parameter int IA_ROW     = CFG_IA_ROW,
    parameter int IA_COL     = CFG_IA_COL,
    parameter int H_STEP     = CFG_H_STEP,
    parameter int NUM_SETS   = CFG_NUM_SETS,
    parameter int IA_CHANNEL = CFG_IA_CHANNEL,
    parameter int W_C_LENGTH = CFG_W_C_LENGTH
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic                          i_layer,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_pe_start,
    input  logic                          i_pe_finish,
    output logic [$clog2(IA_ROW)-1:0]     o_ia_h,
    output logic [$clog2(IA_COL)-1:0]     o_ia_w,
    output logic [1:0]                    o_w_s,
    output logic [$clog2(W_C_LENGTH)-1:0] o_w_len,
    output logic [$clog2(W_C_LENGTH)-1:0] o_w_iters,
    output logic [$clog2(IA_CHANNEL)-1:0] o_ia_len,
    output logic [$clog2(IA_CHANNEL)-1:0] o_ia_iters,
    output logic                          o_oa_valid,
    input  logic                          i_oa_ready
);
    localparam int HW = $clog2(IA_ROW);
    localparam int WW = $clog2(IA_COL);
    localparam int LW = $clog2(W_C_LENGTH);
    localparam int CW = $clog2(IA_CHANNEL);

    state_e        state_q;
    logic          layer_q, busy_q, done_q, pe_start_q, oa_valid_q;
    logic [HW-1:0] ia_h_q, h;
    logic [WW-1:0] ia_w_q, w;
    logic [1:0]    w_s_q, s;
    logic [LW-1:0] w_len_q, w_iters_q, len;
    logic          last;

    tile_counter #(
        .NUM_SETS(NUM_SETS), .IA_ROW(IA_ROW), .H_STEP(H_STEP), .IA_COL(IA_COL)
    ) u_cnt (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clr  (state_q == ST_IDLE && i_start),
        .i_step (state_q == ST_ADV && !last),
        .o_s    (s),
        .o_h    (h),
        .o_w    (w),
        .o_last (last)
    );

    assign len = LW'(w_len_of(layer_q, s));

    // Start stays high through WB so the PE keeps its OA outputs frozen until accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            layer_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pe_start_q <= 1'b0;
            oa_valid_q <= 1'b0;
            ia_h_q     <= '0;
            ia_w_q     <= '0;
            w_s_q      <= '0;
            w_len_q    <= '0;
            w_iters_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (i_start) begin
                    state_q <= ST_LOAD;
                    layer_q <= i_layer;
                    busy_q  <= 1'b1;
                end
                ST_LOAD: begin
                    state_q    <= ST_RUN;
                    ia_h_q     <= h;
                    ia_w_q     <= w;
                    w_s_q      <= s;
                    w_len_q    <= len;
                    w_iters_q  <= LW'(w_iters_of(LEN_W'(len)));
                    pe_start_q <= 1'b1;
                end
                ST_RUN: if (i_pe_finish) begin
                    state_q    <= ST_WB;
                    oa_valid_q <= 1'b1;
                end
                ST_WB: if (i_oa_ready) begin
                    state_q    <= ST_RELEASE;
                    oa_valid_q <= 1'b0;
                    pe_start_q <= 1'b0;
                end
                ST_RELEASE: if (!i_pe_finish) state_q <= ST_ADV;
                ST_ADV: begin
                    state_q <= last ? ST_DONE : ST_LOAD;
                    done_q  <= last;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_pe_start = pe_start_q;
    assign o_oa_valid = oa_valid_q;
    assign o_ia_h     = ia_h_q;
    assign o_ia_w     = ia_w_q;
    assign o_w_s      = w_s_q;
    assign o_w_len    = w_len_q;
    assign o_w_iters  = w_iters_q;
    assign o_ia_len   = CW'(IA_CHANNEL - 1);
    assign o_ia_iters = '0;
endmodule

// File: tb/tb_pe_sched_ctrl.sv
// tb_pe_sched_ctrl: randomized scoreboard bench; a tile-list model predicts each PE start,
// a PE/write-back model answers the handshakes, and a monitor checks every tile it sees
module tb_pe_sched_ctrl;
    localparam int IA_ROW = 16, IA_COL = 16, H_STEP = 16, NSETS = 3;

    logic clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_layer = 1'b0;
    logic i_pe_finish = 1'b0, i_oa_ready = 1'b1;
    logic o_busy, o_done, o_pe_start, o_oa_valid;
    logic [3:0] o_ia_h, o_ia_w;
    logic [1:0] o_w_s;
    logic [8:0] o_w_len, o_w_iters;
    logic [2:0] o_ia_len, o_ia_iters;

    typedef struct {int s; int h; int w; int len; int iters;} tile_t;
    tile_t exp_q[$];
    tile_t cur;
    int lens[2][3] = '{'{123, 130, 124}, '{474, 460, 446}};
    int n_chk = 0, n_fail = 0, tiles_seen = 0, done_cnt = 0;
    int lat = 3, sticky = 0;
    bit rand_lat = 1'b0, rand_rdy = 1'b0;

    always #5 clk = ~clk;

    pe_sched_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_layer(i_layer),
        .o_busy(o_busy), .o_done(o_done), .o_pe_start(o_pe_start), .i_pe_finish(i_pe_finish),
        .o_ia_h(o_ia_h), .o_ia_w(o_ia_w), .o_w_s(o_w_s), .o_w_len(o_w_len),
        .o_w_iters(o_w_iters), .o_ia_len(o_ia_len), .o_ia_iters(o_ia_iters),
        .o_oa_valid(o_oa_valid), .i_oa_ready(i_oa_ready)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Expected tiles in walk order: set outermost, row tile, then column.
    task automatic model_layer(input int layer);
        tile_t t;
        for (int s = 0; s < NSETS; s++)
            for (int h = 0; h <= IA_ROW - H_STEP; h += H_STEP)
                for (int w = 0; w < IA_COL; w++) begin
                    t.s = s; t.h = h; t.w = w;
                    t.len = lens[layer][s];
                    t.iters = (t.len + 31) / 32;
                    exp_q.push_back(t);
                end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_pe_start"}, o_pe_start, 0);
        chk({tag, "_oa_valid"}, o_oa_valid, 0);
        chk({tag, "_ia_h"}, o_ia_h, 0);
        chk({tag, "_ia_w"}, o_ia_w, 0);
        chk({tag, "_w_s"}, o_w_s, 0);
        chk({tag, "_w_len"}, o_w_len, 0);
        chk({tag, "_w_iters"}, o_w_iters, 0);
        chk({tag, "_ia_len"}, o_ia_len, 7);
        chk({tag, "_ia_iters"}, o_ia_iters, 0);
    endtask

    task automatic launch(input bit layer);
        model_layer(int'(layer));
        tiles_seen = 0;
        i_layer = layer;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("launch_busy_c1", o_busy, 1);
        chk("launch_start_c1", o_pe_start, 0);
        step();
        chk("launch_start_c2", o_pe_start, 1);
    endtask

    task automatic wait_tiles(input int n);
        for (int i = 0; i < 3000 && tiles_seen < n; i++) step();
        chk("reach_tile", tiles_seen, n);
    endtask

    task automatic wait_done();
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 5000 && done_cnt == d0; i++) step();
        chk("done_seen", done_cnt - d0, 1);
        chk("busy_in_done", o_busy, 1);
        step();
        step();
        chk("done_single", done_cnt - d0, 1);
        chk("idle_after_done", o_busy, 0);
        chk("tiles_per_layer", tiles_seen, NSETS * (IA_ROW / H_STEP) * IA_COL);
    endtask

    // PE model: finish rises some cycles after start, and may linger after start drops.
    initial begin
        int cnt, stk, cl;
        cnt = 0; stk = 0; cl = 3;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                i_pe_finish = 1'b0; cnt = 0; stk = 0;
            end else if (o_pe_start) begin
                if (cnt == 0) cl = rand_lat ? int'($urandom_range(1, 4)) : lat;
                cnt++;
                if (cnt >= cl) i_pe_finish = 1'b1;
                stk = sticky;
            end else begin
                cnt = 0;
                if (i_pe_finish && stk > 0) stk--;
                else i_pe_finish = 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) i_oa_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pops an expected tile on every PE start and holds config to it until release.
    initial begin
        logic p_start, p_fin, p_done;
        p_start = 1'b0; p_fin = 1'b0; p_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_start = 1'b0; p_fin = 1'b0; p_done = 1'b0;
            end else begin
                if (o_pe_start && !p_start) begin
                    tiles_seen++;
                    chk("start_after_finish_low", int'(p_fin), 0);
                    chk("start_has_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) cur = exp_q.pop_front();
                end
                if (o_pe_start || o_oa_valid) begin
                    chk("cfg_w_s", o_w_s, cur.s);
                    chk("cfg_ia_h", o_ia_h, cur.h);
                    chk("cfg_ia_w", o_ia_w, cur.w);
                    chk("cfg_w_len", o_w_len, cur.len);
                    chk("cfg_w_iters", o_w_iters, cur.iters);
                    chk("cfg_ia_len", o_ia_len, 7);
                    chk("cfg_ia_iters", o_ia_iters, 0);
                    chk("busy_in_tile", o_busy, 1);
                end
                if (o_oa_valid) chk("valid_holds_start", o_pe_start, 1);
                if (o_done) begin
                    done_cnt++;
                    chk("done_one_cycle", int'(p_done), 0);
                    chk("done_after_all_tiles", exp_q.size(), 0);
                end
                p_start = o_pe_start;
                p_fin = i_pe_finish;
                p_done = o_done;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk_reset_outs("por");
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_reset_outs("idle");

        // L1, fixed latency: backpressure on tile 5, stray start on tile 10
        launch(1'b0);
        wait_tiles(6);
        i_oa_ready = 1'b0;
        for (int i = 0; i < 50 && !o_oa_valid; i++) step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", o_oa_valid, 1);
            chk("bp_start", o_pe_start, 1);
            chk("bp_ia_w", o_ia_w, 5);
            chk("bp_w_len", o_w_len, 123);
            step();
        end
        i_oa_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_valid_drop", o_oa_valid, 0);
            chk("bp_restart_gap", o_pe_start, int'(i == 3));
        end
        wait_tiles(11);
        i_start = 1'b1;
        i_layer = 1'b1;
        step();
        i_start = 1'b0;
        i_layer = 1'b0;
        wait_done();

        // L2, random latency and random ready, sticky finish on tile 7
        rand_lat = 1'b1;
        rand_rdy = 1'b1;
        launch(1'b1);
        wait_tiles(8);
        sticky = 4;
        for (int i = 0; i < 100 && o_pe_start; i++) step();
        chk("sticky_start_drop", o_pe_start, 0);
        sticky = 0;
        for (int i = 0; i < 8; i++) begin
            chk("sticky_gap", o_pe_start, int'(i == 7));
            step();
        end
        wait_done();
        rand_rdy = 1'b0;
        i_oa_ready = 1'b1;
        rand_lat = 1'b0;

        // L1 aborted by asynchronous reset during RUN of tile 20, then a clean rerun
        launch(1'b0);
        wait_tiles(21);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_reset_outs("postrst");
        rand_lat = 1'b1;
        launch(1'b0);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
